// File: rtl/fifo_rd_stream_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the FIFO read streamer.
package fifo_rd_stream_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        STALL  = 2'd2
    } state_e;

    // Beat counter width; a one-word burst still needs a 1-bit counter.
    function automatic int beat_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered skid buffer; entry0 is always the head.
module fifo_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       occ_q, occ_d;
    logic             do_pop;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        occ_d    = occ_q;
        do_pop   = pop && (occ_q != 2'd0);

        case ({push, do_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    entry0_d = push_data;
                    occ_d    = 2'd1;
                end else if (occ_q == 2'd1) begin
                    entry1_d = push_data;
                    occ_d    = 2'd2;
                end
            end
            2'b01: begin
                entry0_d = entry1_q;
                occ_d    = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever survives the pop.
                if (occ_q == 2'd1) begin
                    entry0_d = push_data;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // NOTE: data storage is not reset; occupancy alone decides whether an entry is meaningful.
    always_ff @(posedge clk) begin
        entry0_q <= entry0_d;
        entry1_q <= entry1_d;
    end

    assign head = entry0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pulls words from a standard-mode FIFO and emits them as fixed-length bursts
// on a valid/ready stream; the FSM only reports activity and never gates data.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             burst_done,
    output logic             busy
);

    localparam int                BEAT_W    = beat_width(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [1:0]        occ;
    logic [WIDTH-1:0]  head;
    logic              inflight_q;
    logic              pop;
    logic [1:0]        occ_after;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              burst_done_q, burst_done_d;
    state_e            state_q, state_d;

    fifo_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    // Outputs are forced quiet while rst is high, even before the reset edge lands.
    assign out_valid = !rst && (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = head;
    assign out_last  = out_valid && (beat_q == LAST_BEAT);

    // Occupancy the buffer will hold once the in-flight word lands and any pop retires.
    assign occ_after  = occ + {1'b0, inflight_q} - {1'b0, pop};
    assign fifo_rd_en = !rst && !fifo_empty && (occ_after < 2'd2);

    assign burst_done = burst_done_q;
    assign busy       = !rst && (state_q != IDLE);

    always_comb begin
        beat_d       = beat_q;
        burst_done_d = pop && out_last;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fifo_rd_en) begin
                    state_d = STREAM;
                end
            end
            STREAM, STALL: begin
                if ((occ_after == 2'd0) && !fifo_rd_en) begin
                    state_d = IDLE;
                end else if (out_valid && !out_ready) begin
                    state_d = STALL;
                end else begin
                    state_d = STREAM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            beat_q       <= '0;
            burst_done_q <= 1'b0;
            state_q      <= IDLE;
        end else begin
            inflight_q   <= fifo_rd_en;
            beat_q       <= beat_d;
            burst_done_q <= burst_done_d;
            state_q      <= state_d;
        end
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter WIDTH, default `WIDTH, data word width in bits.
REQ-002 Parameter BURST_LEN, default 4, words per burst (legal range 1..256).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 fifo_empty  input  1  empty flag of the upstream standard-mode FIFO.
REQ-006 fifo_data  input  WIDTH  FIFO read data; valid exactly 1 cycle after fifo_rd_en was high.
REQ-007 fifo_rd_en  output  1  FIFO read strobe; one word popped per high cycle.
REQ-008 out_valid  output  1  output word valid.
REQ-009 out_ready  input  1  downstream accepts word.
REQ-010 out_data  output  WIDTH  output word.
REQ-011 out_last  output  1  marks the final word of a burst; qualified by out_valid.
REQ-012 burst_done  output  1  one-cycle pulse, cycle after the handshake of an out_last word.
REQ-013 busy  output  1  high when state != IDLE.

Function
REQ-014 Handshake: transfer when out_valid && out_ready; out_data/out_last SHALL stay stable while out_valid && !out_ready.
REQ-015 Buffer: 2-entry FIFO-ordered skid buffer (occ 0..2); out_valid = (occ != 0); out_data = head entry.
REQ-016 inflight: 1-bit register = fifo_rd_en of previous cycle; when inflight, fifo_data SHALL be written into the buffer that cycle.
REQ-017 fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2, where pop = out_valid && out_ready; buffer SHALL never overflow.
REQ-018 Latency: fifo_rd_en at cycle t -> word in buffer end of t+1 -> out_valid at t+2 (when buffer was empty).
REQ-019 Throughput: with out_ready held high and FIFO non-empty, one word per cycle sustained.
REQ-020 Simultaneous push and pop at occ=2 is impossible by REQ-017; at occ=1 SHALL leave occ=1 with new word as head after pop.
REQ-021 Beat counter 0..BURST_LEN-1 (width $clog2(BURST_LEN) min 1); increments on handshake, wraps to 0 after BURST_LEN-1.
REQ-022 out_last = out_valid && (beat_cnt == BURST_LEN-1); BURST_LEN=1 -> every word has out_last.
REQ-023 Bursts SHALL NOT be truncated by fifo_empty; out_valid drops mid-burst, beat_cnt holds.
REQ-024 FSM: IDLE (occ=0, inflight=0) -> STREAM on fifo_rd_en; STREAM -> STALL when out_valid && !out_ready; STALL -> STREAM on out_ready; STREAM/STALL -> IDLE when occ=0, inflight=0 and fifo_rd_en=0 in next state.
REQ-025 State does not gate data path; it drives busy only.

Reset
REQ-026 On rst high at posedge: occ=0, inflight=0, beat_cnt=0, state=IDLE, burst_done=0.
REQ-027 During and after reset cycle: fifo_rd_en=0, out_valid=0, out_last=0, busy=0; out_data don't-care.
REQ-028 Reset mid-burst SHALL discard buffered and in-flight words; next word after reset starts beat 0.

Structure
REQ-029 WIDTH default and BURST_LEN default SHALL live in the shared defines/package with FSM state enum (IDLE, STREAM, STALL).
REQ-030 Skid buffer SHALL be sub-module fifo_skid_buf (push, push_data, pop, head, occ); controller and beat counter in top.

Verification
REQ-031 Reset then 4 words in FIFO, out_ready=1, BURST_LEN=4 -> fifo_rd_en cycles 1..4, out_valid cycles 3..6, out_last on 4th word, burst_done cycle 7.
REQ-032 FIFO holds 10 words, out_ready=0 -> exactly 2 fifo_rd_en pulses, occ=2, out_data=word0 stable; release out_ready -> words 0..9 in order, no loss/duplication.
REQ-033 Random out_ready (50%) with 1000 random words -> output sequence equals input; out_last every 4th word; no fifo_rd_en while fifo_empty.
REQ-034 FIFO runs empty after 2 of 4 words, refills 5 cycles later -> 3rd word beat_cnt=2, out_last on 4th word only.
REQ-035 rst asserted with occ=2, inflight=1, beat_cnt=3 -> next cycle all outputs 0, subsequent first word beat 0.
REQ-036 BURST_LEN=1, out_ready=1 -> out_last and burst_done on every word.
